// File: rtl/motoro3_pkg.sv
// motoro3_pkg: shared phase-state encoding, counter width and default timing for the motor gate path
package motoro3_pkg;
  localparam int CNT_W = 8;
  localparam int unsigned MOTORO3_DT_DEFAULT = 20;
  localparam int unsigned MOTORO3_MINP_DEFAULT = 5;
  typedef logic [CNT_W-1:0] cnt_t;
  typedef enum logic [2:0] {
    PH_OFF  = 3'd0,
    PH_HIGH = 3'd1,
    PH_LOW  = 3'd2,
    PH_DEAD = 3'd3,
    PH_HOLD = 3'd4
  } phase_e;
endpackage

// File: rtl/motoro3_dt_phase.sv
// motoro3_dt_phase: one phase gate FSM with dead-time and minimum-pulse counters
module motoro3_dt_phase
  import motoro3_pkg::*;
#(
  parameter int unsigned DT_CYCLES = MOTORO3_DT_DEFAULT,
  parameter int unsigned MIN_PULSE = MOTORO3_MINP_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  input  logic req_h_i,
  input  logic req_l_i,
  input  logic flt_i,
  input  logic clr_i,
  output logic g_h_o,
  output logic g_l_o,
  output logic shoot_o
);
  localparam cnt_t DT_LAST = cnt_t'(DT_CYCLES - 1);
  localparam cnt_t MINP = cnt_t'(MIN_PULSE);
  phase_e state_q, state_d, idle_d;
  cnt_t dcnt_q, dcnt_d, ocnt_q, ocnt_d, ocnt_inc;
  logic want_h, want_l, min_ok, enter_dead;
  logic g_h_q, g_l_q, shoot_q;
  always_comb begin
    want_h = en_i & req_h_i & ~req_l_i;
    want_l = en_i & req_l_i & ~req_h_i;
    ocnt_inc = (ocnt_q == MINP) ? ocnt_q : ocnt_q + cnt_t'(1);
    // the incremented count equals cycles already spent on after this edge
    min_ok = ocnt_inc == MINP;
    idle_d = want_h ? PH_HIGH : want_l ? PH_LOW : PH_OFF;
    state_d = state_q;
    if (flt_i) state_d = PH_HOLD;
    else if (clr_i) state_d = PH_DEAD;
    else begin
      unique case (state_q)
        PH_OFF:  state_d = idle_d;
        PH_HIGH: state_d = want_h ? PH_HIGH : (min_ok || !en_i) ? PH_DEAD : PH_HIGH;
        PH_LOW:  state_d = want_l ? PH_LOW : (min_ok || !en_i) ? PH_DEAD : PH_LOW;
        PH_DEAD: state_d = (dcnt_q == DT_LAST) ? idle_d : PH_DEAD;
        default: state_d = PH_HOLD;
      endcase
    end
    enter_dead = (state_d == PH_DEAD) && ((state_q != PH_DEAD) || clr_i);
    dcnt_d = (state_d == PH_DEAD && !enter_dead) ? dcnt_q + cnt_t'(1) : '0;
    ocnt_d = (state_d == state_q) ? ocnt_inc : '0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= PH_OFF;
      dcnt_q <= '0;
      ocnt_q <= '0;
      g_h_q <= 1'b0;
      g_l_q <= 1'b0;
      shoot_q <= 1'b0;
    end else begin
      state_q <= state_d;
      dcnt_q <= dcnt_d;
      ocnt_q <= ocnt_d;
      g_h_q <= state_d == PH_HIGH;
      g_l_q <= state_d == PH_LOW;
      shoot_q <= (req_h_i & req_l_i) | (shoot_q & ~clr_i);
    end
  end
  assign g_h_o = g_h_q;
  assign g_l_o = g_l_q;
  assign shoot_o = shoot_q;
endmodule

// File: rtl/motoro3_deadtime_guard.sv
// motoro3_deadtime_guard: three-phase gate guard with dead time, minimum pulse and latched fault shutdown
module motoro3_deadtime_guard
  import motoro3_pkg::*;
#(
  parameter int unsigned DT_CYCLES = MOTORO3_DT_DEFAULT,
  parameter int unsigned MIN_PULSE = MOTORO3_MINP_DEFAULT
) (
  input  logic       clk,
  input  logic       nRst,
  input  logic       guardEn,
  input  logic [2:0] reqHp,
  input  logic [2:0] reqLp,
  input  logic       fltIn,
  input  logic       clrFault,
  output logic [2:0] gHp,
  output logic [2:0] gLp,
  output logic       fltLatched,
  output logic [2:0] shootThru
);
  logic flt_q, clr_ok;
  // a live fault overrides any clear request in the same cycle
  assign clr_ok = clrFault & ~fltIn;
  always_ff @(posedge clk) begin
    if (nRst) flt_q <= 1'b0;
    else flt_q <= fltIn | (flt_q & ~clrFault);
  end
  assign fltLatched = flt_q;
  for (genvar p = 0; p < 3; p++) begin : g_ph
    motoro3_dt_phase #(
      .DT_CYCLES(DT_CYCLES),
      .MIN_PULSE(MIN_PULSE)
    ) u_ph (
      .clk(clk),
      .rst(nRst),
      .en_i(guardEn),
      .req_h_i(reqHp[p]),
      .req_l_i(reqLp[p]),
      .flt_i(fltIn),
      .clr_i(clr_ok),
      .g_h_o(gHp[p]),
      .g_l_o(gLp[p]),
      .shoot_o(shootThru[p])
    );
  end
endmodule

// File: doc/motoro3_deadtime_guard.md
Name: motoro3_deadtime_guard

Overview:
Downstream stage of the three-phase motor core. Takes the six raw high/low-side requests from the three sine generators and produces the six gate-drive outputs. Guarantees that the high and low sides of a phase are never on together, inserts programmable dead time on every side change, and enforces a minimum on-pulse. Adds a latched hardware fault shutdown. Sits between the motor core and the FPGA output pins.

Parameters:
DT_CYCLES, 20, dead time in clk cycles (2 us at 10 MHz); legal range 1..255.
MIN_PULSE, 5, minimum on-time of any gate output in clk cycles; legal range 1..255.

Ports:
clk  input  1  system clock, 10 MHz.
nRst  input  1  reset; synchronous, active-high (nRst=1 resets on the rising clk edge).
guardEn  input  1  1 = follow requests; 0 = force every phase off.
reqHp  input  3  raw high-side requests; bit0=A, bit1=B, bit2=C.
reqLp  input  3  raw low-side requests; same bit order.
fltIn  input  1  external overcurrent fault, active-high, already synchronised.
clrFault  input  1  single-cycle pulse; clears the latched fault and the shoot-through flags.
gHp  output  3  gate high-side drives, registered.
gLp  output  3  gate low-side drives, registered.
fltLatched  output  1  sticky fault indicator.
shootThru  output  3  sticky per-phase flag: both requests seen high together.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- All outputs are registered. Reset value of gHp, gLp, fltLatched and shootThru is 0. Phase state after reset: OFF, counters 0.
- Per-phase request decode, sampled each edge:
  - H-only -> want HIGH.
  - L-only -> want LOW.
  - Neither -> want OFF.
  - Both -> want OFF, and shootThru[p] is set.
- Per-phase FSM:
  - OFF (g=00): want HIGH -> HIGH; want LOW -> LOW; else stay in OFF.
  - HIGH (gHp=1): stay while want HIGH. Otherwise, once the on-counter reaches MIN_PULSE, go to DEAD.
  - LOW: mirror of HIGH.
  - DEAD (g=00): lasts exactly DT_CYCLES clocks. At expiry, go to HIGH, LOW or OFF per the current want. Requests changing during DEAD are ignored until expiry.
- Latency and timing:
  - OFF->HIGH/LOW: output rises on the same edge that samples the request (1-cycle latency from input to pin).
  - LOW->HIGH: gLp falls at edge k; gHp rises at edge k+DT_CYCLES.
  - Minimum on-time: entering HIGH/LOW clears the on-counter. The on-counter saturates at MIN_PULSE. An output, once high, stays high at least MIN_PULSE cycles unless forced off (below).
- Force-off precedence: nRst > fault > guardEn=0.
  - Fault: fltIn=1 sets fltLatched and drives all gates to 0 on the same edge. All phases enter HOLD, which behaves like OFF but ignores requests. The minimum pulse is not honoured.
  - Fault clear: clrFault=1 with fltIn=0 clears fltLatched and all shootThru bits, and moves every phase to DEAD (full DT_CYCLES). clrFault while fltIn=1 is ignored.
  - guardEn=0: every phase not in HOLD goes to DEAD on the next edge, then OFF, and stays OFF while disabled.
- Simultaneous events:
  - fltIn and clrFault in the same cycle: fault wins.
  - Both-request flag set in the same cycle as clrFault: the flag ends at 1 (set wins).
- Invariant: gHp[p] & gLp[p] is never 1 on any cycle, including reset and fault transitions.
- Counters: 8-bit per phase, saturating, no wrap.

Decomposition:
- Shared package motoro3_pkg holds:
  - phase state encoding (OFF, HIGH, LOW, DEAD, HOLD), 3 bits;
  - default constants MOTORO3_DT_DEFAULT=20 and MOTORO3_MINP_DEFAULT=5;
  - counter width 8.
- Sub-module motoro3_dt_phase: one phase FSM with its dead and on counters, instantiated three times. The top holds only the fault latch and the fan-out.

Test Plan:
- Reset: drive nRst=1 for 2 cycles with all requests high -> gHp=gLp=000, fltLatched=0, shootThru=000.
- Phase A in LOW, reqLp[0]->0 and reqHp[0]->1 at edge k -> gLp[0]=0 at k, gHp[0]=1 at k+20, both low for exactly 20 cycles.
- Phase B OFF, reqHp[1] pulse of 2 cycles -> gHp[1] high for exactly 5 cycles, then 20 cycles of DEAD, then OFF.
- Phase C reqHp=reqLp=1 for 1 cycle while HIGH (after min pulse) -> C goes to DEAD, shootThru=100 and stays set until clrFault.
- All phases running, fltIn=1 at edge k -> all gates 0 at k, fltLatched=1. clrFault with fltIn=1 leaves it latched. After fltIn=0, clrFault at edge m -> fltLatched=0, shootThru=000, gates stay 0 until m+20, then follow requests.
- guardEn 1->0 mid HIGH (on-time 2 cycles) -> gate 0 on the next edge, stays 0 while disabled. Re-enable from OFF -> request honoured in 1 cycle.
